// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and seven-segment constants for counter_ctrl
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segments a..g MSB-first, active-low
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

endpackage

// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - command and display bus between controller and its driver
interface counter_ctrl_if;
    logic        start;
    logic        pause;
    logic        clear;
    logic        dir;
    logic        wrap_en;
    logic [13:0] seg;
    logic [6:0]  count;
    logic        running;
    logic        at_limit;

    modport slave (
        input  start, pause, clear, dir, wrap_en,
        output seg, count, running, at_limit
    );

    modport master (
        output start, pause, clear, dir, wrap_en,
        input  seg, count, running, at_limit
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - decimal digit to active-low seven-segment pattern
module bcd_to_seg7
    import counter_ctrl_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);
    assign o_seg = (i_digit <= 4'd9) ? SEG_DIGIT[i_digit] : SEG_BLANK;
endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - start/pause/clear sequenced up/down counter with two-digit display
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int PRESCALE  = 4,
    parameter int MAX_COUNT = 99
) (
    input  logic          clk,
    input  logic          rst,
    counter_ctrl_if.slave bus
);
    localparam int             PW      = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
    localparam logic [6:0]     CNT_MAX = 7'(MAX_COUNT);

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [6:0]    r_count, w_count_nxt;
    logic          r_at_limit, w_at_limit_nxt;
    logic          w_tick;
    logic          w_lim;
    logic          w_go;
    logic [3:0]    w_tens;
    logic [3:0]    w_units;
    logic [6:0]    w_seg_tens;
    logic [6:0]    w_seg_units;

    assign w_tick = (r_state == RUN) && (r_presc == PS_LAST);
    assign w_lim  = bus.dir ? (r_count == CNT_MAX) : (r_count == 7'd0);
    assign w_go   = bus.start && !bus.pause;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_presc    <= '0;
            r_count    <= 7'd0;
            r_at_limit <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_count    <= w_count_nxt;
            r_at_limit <= w_at_limit_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_count_nxt = r_count;
        case (r_state)
            IDLE:  if (w_go) w_state_nxt = RUN;
            RUN: begin
                if (bus.pause)
                    w_state_nxt = PAUSE;
                else if (w_tick && w_lim && !bus.wrap_en)
                    w_state_nxt = DONE;
                w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
            end
            PAUSE: if (w_go) w_state_nxt = RUN;
            // Leaving DONE needs a direction that points away from the held limit
            DONE:  if (w_go && !w_lim) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
        if (w_tick) begin
            if (!w_lim)
                w_count_nxt = bus.dir ? r_count + 7'd1 : r_count - 7'd1;
            else if (bus.wrap_en)
                w_count_nxt = bus.dir ? 7'd0 : CNT_MAX;
        end
        if (bus.clear) begin
            w_state_nxt = IDLE;
            w_presc_nxt = '0;
            w_count_nxt = 7'd0;
        end
        w_at_limit_nxt = bus.dir ? (w_count_nxt == CNT_MAX) : (w_count_nxt == 7'd0);
    end

    // Decimal split by comparing against multiples of ten
    always_comb begin
        w_tens = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (r_count >= 7'(10 * k))
                w_tens = 4'(k);
        end
        w_units = 4'(r_count - 7'(10 * w_tens));
    end

    bcd_to_seg7 u_seg_tens (
        .i_digit (w_tens),
        .o_seg   (w_seg_tens)
    );

    bcd_to_seg7 u_seg_units (
        .i_digit (w_units),
        .o_seg   (w_seg_units)
    );

    assign bus.seg      = {(r_count < 7'd10) ? SEG_BLANK : w_seg_tens, w_seg_units};
    assign bus.count    = r_count;
    assign bus.running  = (r_state == RUN);
    assign bus.at_limit = r_at_limit;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl against a behavioural model
module tb_counter_ctrl;
    localparam int PA = 4;
    localparam int MA = 99;
    localparam int PB = 1;
    localparam int MB = 12;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
    localparam logic [13:0] SEG_ZERO = 14'b11111110000001;

    typedef struct {
        int st;
        int ps;
        int cnt;
        bit al;
    } mdl_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    counter_ctrl_if ifa ();
    counter_ctrl_if ifb ();

    assign ifb.start   = ifa.start;
    assign ifb.pause   = ifa.pause;
    assign ifb.clear   = ifa.clear;
    assign ifb.dir     = ifa.dir;
    assign ifb.wrap_en = ifa.wrap_en;

    counter_ctrl #(.PRESCALE(PA), .MAX_COUNT(MA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    counter_ctrl #(.PRESCALE(PB), .MAX_COUNT(MB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    function automatic logic [6:0] dcode(int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    function automatic logic [13:0] exp_seg(int c);
        logic [6:0] t;
        t = (c < 10) ? 7'b1111111 : dcode(c / 10);
        return {t, dcode(c % 10)};
    endfunction

    function automatic mdl_t mstep(mdl_t m, int mx, int pr);
        mdl_t n;
        bit   tick, lim, go;
        n = m;
        if (rst) begin
            n.st = S_IDLE; n.ps = 0; n.cnt = 0; n.al = 0;
            return n;
        end
        tick = (m.st == S_RUN) && (m.ps == pr - 1);
        lim  = ifa.dir ? (m.cnt == mx) : (m.cnt == 0);
        go   = ifa.start && !ifa.pause;
        if (m.st == S_RUN) n.ps = tick ? 0 : m.ps + 1;
        if (tick) begin
            if (!lim)              n.cnt = ifa.dir ? m.cnt + 1 : m.cnt - 1;
            else if (ifa.wrap_en)  n.cnt = ifa.dir ? 0 : mx;
        end
        if (m.st == S_IDLE && go)                  n.st = S_RUN;
        if (m.st == S_PAUSE && go)                 n.st = S_RUN;
        if (m.st == S_DONE && go && !lim)          n.st = S_RUN;
        if (m.st == S_RUN && ifa.pause)            n.st = S_PAUSE;
        else if (m.st == S_RUN && tick && lim && !ifa.wrap_en) n.st = S_DONE;
        if (ifa.clear) begin
            n.st = S_IDLE; n.ps = 0; n.cnt = 0;
        end
        n.al = ifa.dir ? (n.cnt == mx) : (n.cnt == 0);
        return n;
    endfunction

    task automatic clk_step();
        @(posedge clk);
        ma = mstep(ma, MA, PA);
        mb = mstep(mb, MB, PB);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        n_tests++; if (ifa.count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", ifa.count); end
        n_tests++; if (ifa.seg !== SEG_ZERO) begin n_fail++; $display("FAIL reset_seg: got %b expected %b", ifa.seg, SEG_ZERO); end
        n_tests++; if (ifa.running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", ifa.running); end
        n_tests++; if (ifa.at_limit !== 1'b0) begin n_fail++; $display("FAIL reset_at_limit: got %b expected 0", ifa.at_limit); end
    endtask

    task automatic test_count_up();
        int          at [3];
        logic [13:0] val [3];
        int          exp_at [3];
        logic [13:0] exp_v [3];
        logic [13:0] prev;
        int          k;
        exp_at = '{4, 8, 12};
        exp_v  = '{14'b11111111001111, 14'b11111110010010, 14'b11111110000110};
        ifa.dir = 1'b1; ifa.wrap_en = 1'b1; ifa.start = 1'b1;
        clk_step();
        ifa.start = 1'b0;
        n_tests++; if (ifa.running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b expected 1", ifa.running); end
        prev = ifa.seg; k = 0;
        for (int i = 0; i < 3; i++) begin at[i] = -1; val[i] = '0; end
        for (int i = 1; i <= 14; i++) begin
            clk_step();
            if (ifa.seg !== prev) begin
                if (k < 3) begin at[k] = i; val[k] = ifa.seg; end
                k++;
                prev = ifa.seg;
            end
        end
        n_tests++; if (k != 3) begin n_fail++; $display("FAIL up_changes: got %0d expected 3", k); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (at[i] != exp_at[i]) begin n_fail++; $display("FAIL up_time%0d: got %0d expected %0d", i, at[i], exp_at[i]); end
            n_tests++; if (val[i] !== exp_v[i]) begin n_fail++; $display("FAIL up_seg%0d: got %b expected %b", i, val[i], exp_v[i]); end
        end
    endtask

    task automatic test_wrap();
        int g;
        for (g = 0; g < 40 && ifb.count !== 7'd12; g++) clk_step();
        n_tests++; if (ifb.count !== 7'd12) begin n_fail++; $display("FAIL wrap_reach: got %0d expected 12", ifb.count); end
        clk_step();
        n_tests++; if (ifb.count !== 7'd0) begin n_fail++; $display("FAIL wrap_up_count: got %0d expected 0", ifb.count); end
        n_tests++; if (ifb.seg !== SEG_ZERO) begin n_fail++; $display("FAIL wrap_up_seg: got %b expected %b", ifb.seg, SEG_ZERO); end
        ifa.dir = 1'b0;
        clk_step();
        n_tests++; if (ifb.count !== 7'd12) begin n_fail++; $display("FAIL wrap_dn_count: got %0d expected 12", ifb.count); end
        n_tests++; if (ifb.seg !== 14'b10011110010010) begin n_fail++; $display("FAIL wrap_dn_seg: got %b expected 10011110010010", ifb.seg); end
    endtask

    task automatic test_saturate();
        int g;
        ifa.dir = 1'b1; ifa.wrap_en = 1'b0;
        for (g = 0; g < 600 && ifa.count !== 7'd99; g++) clk_step();
        n_tests++; if (ifa.count !== 7'd99) begin n_fail++; $display("FAIL sat_reach: got %0d expected 99", ifa.count); end
        repeat (PA) clk_step();
        n_tests++; if (ifa.running !== 1'b0) begin n_fail++; $display("FAIL sat_running: got %b expected 0", ifa.running); end
        n_tests++; if (ifa.at_limit !== 1'b1) begin n_fail++; $display("FAIL sat_at_limit: got %b expected 1", ifa.at_limit); end
        n_tests++; if (ifa.count !== 7'd99) begin n_fail++; $display("FAIL sat_hold: got %0d expected 99", ifa.count); end
        ifa.dir = 1'b1; ifa.start = 1'b1;
        clk_step();
        n_tests++; if (ifa.running !== 1'b0) begin n_fail++; $display("FAIL sat_same_dir: got %b expected 0", ifa.running); end
        ifa.dir = 1'b0;
        clk_step();
        ifa.start = 1'b0;
        n_tests++; if (ifa.running !== 1'b1) begin n_fail++; $display("FAIL sat_resume: got %b expected 1", ifa.running); end
        repeat (PA) clk_step();
        n_tests++; if (ifa.count !== 7'd98) begin n_fail++; $display("FAIL sat_down: got %0d expected 98", ifa.count); end
    endtask

    task automatic test_pause();
        int  g;
        int  c0;
        bit  moved;
        for (g = 0; g < 10 && !(ma.st == S_RUN && ma.ps == 1); g++) clk_step();
        n_tests++; if (!(ma.st == S_RUN && ma.ps == 1)) begin n_fail++; $display("FAIL pause_setup: got ps %0d expected 1", ma.ps); end
        ifa.pause = 1'b1;
        c0 = int'(ifa.count);
        moved = 0;
        repeat (10) begin
            clk_step();
            if (int'(ifa.count) != c0 || ifa.running !== 1'b0) moved = 1;
        end
        ifa.pause = 1'b0;
        n_tests++; if (moved) begin n_fail++; $display("FAIL pause_hold: got count %0d expected %0d", ifa.count, c0); end
        ifa.start = 1'b1;
        clk_step();
        ifa.start = 1'b0;
        clk_step();
        n_tests++; if (int'(ifa.count) != c0) begin n_fail++; $display("FAIL pause_early: got %0d expected %0d", ifa.count, c0); end
        clk_step();
        n_tests++; if (int'(ifa.count) != c0 - 1) begin n_fail++; $display("FAIL pause_resume: got %0d expected %0d", ifa.count, c0 - 1); end
    endtask

    task automatic test_clear_tick();
        int g;
        ifa.dir = 1'b1; ifa.wrap_en = 1'b1; ifa.clear = 1'b1;
        clk_step();
        ifa.clear = 1'b0; ifa.start = 1'b1;
        clk_step();
        ifa.start = 1'b0;
        for (g = 0; g < 60 && !(ma.cnt == 7 && ma.ps == PA - 1 && ma.st == S_RUN); g++) clk_step();
        n_tests++; if (ifa.count !== 7'd7) begin n_fail++; $display("FAIL clr_setup: got %0d expected 7", ifa.count); end
        ifa.clear = 1'b1;
        clk_step();
        ifa.clear = 1'b0;
        n_tests++; if (ifa.count !== 7'd0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", ifa.count); end
        n_tests++; if (ifa.seg !== SEG_ZERO) begin n_fail++; $display("FAIL clr_seg: got %b expected %b", ifa.seg, SEG_ZERO); end
        n_tests++; if (ifa.running !== 1'b0) begin n_fail++; $display("FAIL clr_running: got %b expected 0", ifa.running); end
        n_tests++; if (ifa.at_limit !== 1'b0) begin n_fail++; $display("FAIL clr_at_limit: got %b expected 0", ifa.at_limit); end
    endtask

    task automatic test_reset_combo();
        ifa.start = 1'b1;
        clk_step();
        ifa.start = 1'b0;
        repeat (6) clk_step();
        rst = 1'b1; ifa.start = 1'b1; ifa.clear = 1'b1; ifa.dir = 1'b0;
        clk_step();
        rst = 1'b0; ifa.start = 1'b0; ifa.clear = 1'b0;
        n_tests++; if (ifa.count !== 7'd0) begin n_fail++; $display("FAIL rstc_count: got %0d expected 0", ifa.count); end
        n_tests++; if (ifa.seg !== SEG_ZERO) begin n_fail++; $display("FAIL rstc_seg: got %b expected %b", ifa.seg, SEG_ZERO); end
        n_tests++; if (ifa.running !== 1'b0) begin n_fail++; $display("FAIL rstc_running: got %b expected 0", ifa.running); end
        n_tests++; if (ifa.at_limit !== 1'b0) begin n_fail++; $display("FAIL rstc_at_limit: got %b expected 0", ifa.at_limit); end
        n_tests++; if (ifb.running !== 1'b0) begin n_fail++; $display("FAIL rstc_b_running: got %b expected 0", ifb.running); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom % 97) == 0;
            ifa.clear = ($urandom % 41) == 0;
            ifa.start = ($urandom % 3) == 0;
            ifa.pause = ($urandom % 7) == 0;
            if (($urandom % 17) == 0) ifa.dir = ~ifa.dir;
            if (($urandom % 29) == 0) ifa.wrap_en = ~ifa.wrap_en;
            clk_step();
            n_tests++; if (int'(ifa.count) != ma.cnt) begin n_fail++; $display("FAIL rnd_a_count @%0d: got %0d expected %0d", i, ifa.count, ma.cnt); end
            n_tests++; if (ifa.seg !== exp_seg(ma.cnt)) begin n_fail++; $display("FAIL rnd_a_seg @%0d: got %b expected %b", i, ifa.seg, exp_seg(ma.cnt)); end
            n_tests++; if (ifa.running !== (ma.st == S_RUN)) begin n_fail++; $display("FAIL rnd_a_running @%0d: got %b expected %b", i, ifa.running, ma.st == S_RUN); end
            n_tests++; if (ifa.at_limit !== ma.al) begin n_fail++; $display("FAIL rnd_a_at_limit @%0d: got %b expected %b", i, ifa.at_limit, ma.al); end
            n_tests++; if (int'(ifb.count) != mb.cnt) begin n_fail++; $display("FAIL rnd_b_count @%0d: got %0d expected %0d", i, ifb.count, mb.cnt); end
            n_tests++; if (ifb.seg !== exp_seg(mb.cnt)) begin n_fail++; $display("FAIL rnd_b_seg @%0d: got %b expected %b", i, ifb.seg, exp_seg(mb.cnt)); end
            n_tests++; if (ifb.running !== (mb.st == S_RUN)) begin n_fail++; $display("FAIL rnd_b_running @%0d: got %b expected %b", i, ifb.running, mb.st == S_RUN); end
            n_tests++; if (ifb.at_limit !== mb.al) begin n_fail++; $display("FAIL rnd_b_at_limit @%0d: got %b expected %b", i, ifb.at_limit, mb.al); end
        end
        rst = 1'b0; ifa.clear = 1'b0; ifa.start = 1'b0; ifa.pause = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifa.start = 1'b0; ifa.pause = 1'b0; ifa.clear = 1'b0;
        ifa.dir = 1'b1; ifa.wrap_en = 1'b1;
        ma = '{S_IDLE, 0, 0, 1'b0};
        mb = '{S_IDLE, 0, 0, 1'b0};
        test_reset();
        test_count_up();
        test_wrap();
        test_saturate();
        test_pause();
        test_clear_tick();
        test_reset_combo();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencing controller for the lab's two-digit display counter. Accepts start/pause/clear commands, divides the system clock into count ticks, and steps a 0..MAX_COUNT count up or down, wrapping or saturating. Drives the 14-bit active-low seven-segment bus consumed by the board's display pins, with the same encoding the existing counter uses.

## Interface
- PRESCALE, 4: clk cycles per count tick, ≥1; prescaler width is $clog2(PRESCALE)+1.
- MAX_COUNT, 99: highest count value, 1..99.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  level command: enter or resume RUN.
- pause  in  1  level command: RUN → PAUSE.
- clear  in  1  level command: count ← 0, prescaler ← 0, state ← IDLE.
- dir  in  1  1 = count up, 0 = count down; sampled on each tick.
- wrap_en  in  1  1 = wrap at limits, 0 = saturate and stop.
- seg  out  14  {tens[6:0], units[6:0]}; segments a..g MSB-first, active-low.
- count  out  7  binary count value, 0..MAX_COUNT.
- running  out  1  high while state == RUN.
- at_limit  out  1  count == MAX_COUNT when dir=1; count == 0 when dir=0.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: start → RUN. Count stays where it is.
- RUN: pause → PAUSE. When a tick fires, the count steps according to the rules below.
- PAUSE: start → RUN. The prescaler holds its value, so resume continues the partial period.
- DONE: entered when wrap_en=0 and a tick arrives with the count already at the limit for the current dir.
  - start with the opposite dir → RUN.
  - start with the same dir → stays in DONE.
- Command priority within one cycle: rst > clear > pause > start.
  - start and pause together in RUN → PAUSE.
  - In PAUSE, start and pause together → stays in PAUSE.
- Step rules:
  - Up: count == MAX_COUNT → 0 if wrap_en, else DONE with count held. Otherwise count+1.
  - Down: count == 0 → MAX_COUNT if wrap_en, else DONE with count held. Otherwise count−1.
- Prescaler:
  - Counts 0..PRESCALE−1 only in RUN.
  - The tick is the cycle in which it equals PRESCALE−1; it then returns to 0.
  - PRESCALE=1 ticks every RUN cycle.
- Display:
  - units = count % 10, tens = count / 10.
  - Tens digit is blanked (7'b1111111) when count < 10.
  - Digit codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Changing dir or wrap_en mid-run takes effect at the next tick.

## Timing
- Reset values: state IDLE, prescaler 0, count 0, seg 14'b11111110000001, running 0, at_limit 0.
- All outputs are registered or decoded purely from registered state; there are no combinational input-to-output paths.
- running updates the cycle after the command edge is sampled.
- Latency from start to the first count change is PRESCALE cycles (RUN entry cycle + PRESCALE−1).
- count and seg change together, on the cycle after the tick.
- clear overrides a simultaneous tick: count goes to 0, not 1.
- rst or clear mid-RUN or mid-PAUSE: the next cycle equals the reset values.
  - Exception for clear alone: at_limit is recomputed from dir (count 0, dir=0 → 1).

## Structure
- Package counter_ctrl_pkg:
  - state_t enum {IDLE, RUN, PAUSE, DONE};
  - SEG_BLANK = 7'b1111111;
  - seg7 digit constant array SEG_DIGIT[0:9].
- Sub-module bcd_to_seg7: 4-bit digit in, 7-bit active-low pattern out, purely combinational. Instantiated twice.
- Top: FSM, prescaler, count register, at_limit logic, /10 and %10 split (a constant-divide comparator chain; no divider IP).

## Test plan
- Reset then start, dir=1, PRESCALE=4: seg goes 11111110000001 → 11111111001111 → 11111110010010 → 11111110000110. Each change is exactly 4 cycles apart, and the first comes 4 cycles after start.
- MAX_COUNT=12, wrap_en=1, dir=1 from 12: next tick gives count 0 and seg 11111110000001. With dir=0 from 0, the next tick gives count 12 and seg 10011110010010.
- wrap_en=0, dir=1, count reaches 99: the following tick enters DONE; running=0, at_limit=1, count stays at 99. Then dir=0 with start gives RUN, and the next tick gives 98.
- Pause at prescaler=2 for 10 cycles, then start: the next tick occurs 2 cycles after RUN re-entry and count is unchanged during the pause.
- clear asserted on a tick cycle at count 7: count=0, state IDLE, seg 11111110000001, running=0.
- rst asserted mid-RUN together with start and clear: the next cycle shows all reset values.
